axi_strip_header: RTL and testbench
===================================

Name: axi_strip_header

Overview:
- AXI-Stream header remover; the receive-side counterpart of axi_insert_header.
- Strips the first byte_strip_cnt bytes of every packet and re-aligns the remaining payload to full 32-bit beats.
- Presents the stripped header bytes on a side port.
- Sits on the ingress path after a link/FIFO; the downstream consumer sees payload-only packets.

Parameters:
- DATA_WD, 32, stream data width in bits; must be a multiple of 8.
- DATA_BYTE_WD, DATA_WD/8, byte lanes per beat; default 4.
- CNT_WD, 3, width of byte_strip_cnt.

Ports:
- r_sys_clk  in  1  clock
- r_sys_rstn  in  1  reset; asynchronous, active-low
- valid_in  in  1  input beat valid
- data_in  in  DATA_WD  input beat; byte lane 3 = [31:24] = first byte on the wire
- keep_in  in  DATA_BYTE_WD  byte enables, MSB-contiguous: 1111, 1110, 1100, 1000
- last_in  in  1  last beat of packet
- ready_in  out  1  input accepted when valid_in & ready_in
- valid_out  out  1  output beat valid
- data_out  out  DATA_WD  re-aligned payload; disabled lanes driven 0
- keep_out  out  DATA_BYTE_WD  MSB-contiguous byte enables
- last_out  out  1  last payload beat
- ready_out  in  1  downstream ready
- byte_strip_cnt  in  CNT_WD  header length k in bytes, 0..4 (5..7 saturate to 4); sampled on the first beat of each packet
- valid_header  out  1  one-cycle pulse when the header is captured
- data_header  out  DATA_WD  header bytes, MSB-aligned, zero-filled; held until next capture
- keep_header  out  DATA_BYTE_WD  lanes actually captured = min(k, bytes in first beat)
- err_keep  out  1  sticky keep-legality error (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, except ready_in = 1; state = FIRST; residual cleared.
- Reset is asynchronous and may occur mid-packet. The partial packet is discarded; no last_out is emitted for it.
- Output stage is a single register. valid_out, data_out, keep_out and last_out hold stable while valid_out & !ready_out.
- ready_in = (!valid_out | ready_out) & (state != FLUSH).
- Latency: an output beat appears the cycle after the input handshake that completes it.
- Notation: n = ones(keep_in); k = clamped strip count; residual register res_data with res_cnt = 4 − k valid bytes.

State FIRST (first beat of packet):
- Latch k. Capture the top min(k,n) bytes into data_header / keep_header and pulse valid_header.
- If !last_in: store the bottom 4−k bytes in the residual; no output; go to MID. With k=4 the residual is empty.
- If last_in and n ≤ k: packet is empty; no output beat; stay in FIRST.
- If last_in and n > k: emit the bytes below the header, MSB-aligned, with keep = n−k and last_out = 1; stay in FIRST.

State MID (non-last beat):
- Emit {residual (4−k bytes), top k bytes of data_in} with keep 1111 and last_out = 0.
- New residual = bottom 4−k bytes of data_in.

State MID (last beat), total t = (4−k) + n:
- t ≤ 4: emit the t valid bytes, keep = t ones, last_out = 1; go to FIRST.
- t > 4: emit a full beat with last_out = 0; residual = remaining t−4 bytes; go to FLUSH.

State FLUSH:
- Input is stalled.
- When the output register is free, emit the residual with keep = t−4 ones and last_out = 1; go to FIRST.

Special cases:
- k = 0: pure pass-through with one cycle of latency.
- k = 4: the first beat is dropped entirely and later beats pass through unshifted.

Optional Feature:
- Macro: AXI_STRIP_ERR_EN.
- Defined: err_keep is set and held until reset when either of these is accepted:
  - a beat with non-MSB-contiguous keep_in;
  - a beat with keep_in ≠ 1111 and last_in = 0.
  The data path behaves as above, using n = ones(keep_in).
- Undefined: err_keep is tied to 0 and no check logic is synthesised.

Test Plan:
- k=3; beats 0x10203040, 0x11213141, then 0x12223242 with last, keep 1000.
  → header 0x10203000, keep 1110; out 0x40112131 (1111), then 0x41120000 (1100, last).
- k=1; beats 0xA0A1A2A3, then 0xB0B1B2B3 with last, keep 1111.
  → header 0xA0000000; out 0xA1A2A3B0 (1111), then FLUSH 0xB1B2B300 (1110, last); ready_in low during FLUSH.
- k=0 and k=4; 3-beat packet 0x01..., 0x02..., 0x03... with last keep 1100.
  → k=0: identical beats; k=4: only beats 2 and 3 are output, last keep 1100.
- k=3; single beat 0xC0C10000 with last, keep 1100.
  → no output beat; header 0xC0C10000, keep 1100, valid_header pulse.
- Random valid_in and ready_out toggling over 8-beat packets: no beat lost or duplicated; data_out stable under stall; byte stream equals input minus header.
- With AXI_STRIP_ERR_EN: keep 1010 mid-packet → err_keep = 1 and stays 1; asynchronous reset clears it and returns to FIRST.

Source files
------------

// File: rtl/axi_strip_header.sv
//============================================================================
// Module      : axi_strip_header
// Description : AXI-Stream header remover. Strips the first byte_strip_cnt
//               bytes of every packet, re-aligns the payload to full beats
//               and presents the stripped bytes on a side port.
//               Define AXI_STRIP_ERR_EN to build the sticky keep-legality
//               flag err_keep; otherwise err_keep is tied low.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module axi_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = 3
) (
    input  logic                    r_sys_clk,
    input  logic                    r_sys_rstn,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic [CNT_WD-1:0]       byte_strip_cnt,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    output logic                    err_keep
);

    // Byte counts reach 2*DATA_BYTE_WD (residual plus a full last beat).
    localparam int                      c_BCW      = $clog2(2 * DATA_BYTE_WD + 1);
    localparam logic [c_BCW-1:0]        c_FULL     = c_BCW'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] c_KEEP_ALL = '1;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_MID   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    function automatic logic [c_BCW-1:0] f_ones(input logic [DATA_BYTE_WD-1:0] keep);
        f_ones = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) f_ones = f_ones + c_BCW'(keep[i]);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_msb_mask(input logic [c_BCW-1:0] cnt);
        f_msb_mask = ~(c_KEEP_ALL >> cnt);
    endfunction

    function automatic logic [DATA_WD-1:0] f_expand(input logic [DATA_BYTE_WD-1:0] keep);
        for (int i = 0; i < DATA_BYTE_WD; i++) f_expand[8*i +: 8] = {8{keep[i]}};
    endfunction

    state_t                    r_state, w_state_nxt;
    logic [DATA_WD-1:0]        r_res_data, w_res_data_nxt;
    logic [c_BCW-1:0]          r_res_cnt, w_res_cnt_nxt;
    logic                      r_valid_out, r_last_out;
    logic [DATA_WD-1:0]        r_data_out;
    logic [DATA_BYTE_WD-1:0]   r_keep_out;
    logic                      r_valid_header;
    logic [DATA_WD-1:0]        r_data_header;
    logic [DATA_BYTE_WD-1:0]   r_keep_header;

    logic                      w_acc, w_out_free, w_emit, w_olast, w_hdr_ld;
    logic [DATA_WD-1:0]        w_odata, w_data_m, w_first_tail, w_hdr_data;
    logic [DATA_BYTE_WD-1:0]   w_okeep, w_hdr_keep;
    logic [c_BCW-1:0]          w_k_in, w_n, w_t, w_hdr_cnt;
    logic [2*DATA_WD-1:0]      w_cat;

    assign w_out_free = !r_valid_out || ready_out;
    assign ready_in   = w_out_free && (r_state != S_FLUSH);
    assign w_acc      = valid_in && ready_in;

    // Strip counts above one beat saturate to a whole beat.
    assign w_k_in = (c_BCW'(byte_strip_cnt) > c_FULL) ? c_FULL : c_BCW'(byte_strip_cnt);
    assign w_n    = f_ones(keep_in);

    // Lanes are taken as the top n bytes so the data path stays consistent
    // with the byte count even for an illegal keep pattern.
    assign w_data_m     = data_in & f_expand(f_msb_mask(w_n));
    assign w_first_tail = w_data_m << {w_k_in, 3'b000};
    assign w_hdr_cnt    = (w_k_in < w_n) ? w_k_in : w_n;
    assign w_hdr_keep   = f_msb_mask(w_hdr_cnt);
    assign w_hdr_data   = w_data_m & f_expand(w_hdr_keep);

    // Residual bytes followed directly by the incoming beat, MSB-aligned.
    assign w_cat = {r_res_data, {DATA_WD{1'b0}}}
                 | ({w_data_m, {DATA_WD{1'b0}}} >> {r_res_cnt, 3'b000});
    assign w_t   = r_res_cnt + w_n;

    // State register; asynchronous reset drops any partial packet.
    always_ff @(posedge r_sys_clk or negedge r_sys_rstn) begin
        if (!r_sys_rstn) r_state <= S_FIRST;
        else             r_state <= w_state_nxt;
    end

    // Next state, residual update and output-beat construction.
    always_comb begin
        w_state_nxt    = r_state;
        w_res_data_nxt = r_res_data;
        w_res_cnt_nxt  = r_res_cnt;
        w_emit         = 1'b0;
        w_odata        = '0;
        w_okeep        = '0;
        w_olast        = 1'b0;
        w_hdr_ld       = 1'b0;
        case (r_state)
            S_FIRST: begin
                if (w_acc) begin
                    w_hdr_ld = 1'b1;
                    if (w_k_in == '0) begin
                        // Nothing to strip: forward the beat as-is.
                        w_emit         = 1'b1;
                        w_odata        = w_data_m;
                        w_okeep        = f_msb_mask(w_n);
                        w_olast        = last_in;
                        w_res_data_nxt = '0;
                        w_res_cnt_nxt  = '0;
                        w_state_nxt    = last_in ? S_FIRST : S_MID;
                    end else if (!last_in) begin
                        w_res_data_nxt = w_first_tail;
                        w_res_cnt_nxt  = c_FULL - w_k_in;
                        w_state_nxt    = S_MID;
                    end else if (w_n > w_k_in) begin
                        w_emit  = 1'b1;
                        w_odata = w_first_tail;
                        w_okeep = f_msb_mask(w_n - w_k_in);
                        w_olast = 1'b1;
                    end
                end
            end
            S_MID: begin
                if (w_acc) begin
                    w_emit  = 1'b1;
                    w_odata = w_cat[2*DATA_WD-1:DATA_WD];
                    w_okeep = c_KEEP_ALL;
                    if (!last_in) begin
                        w_res_data_nxt = w_cat[DATA_WD-1:0];
                    end else if (w_t <= c_FULL) begin
                        w_okeep        = f_msb_mask(w_t);
                        w_olast        = 1'b1;
                        w_res_data_nxt = '0;
                        w_res_cnt_nxt  = '0;
                        w_state_nxt    = S_FIRST;
                    end else begin
                        w_res_data_nxt = w_cat[DATA_WD-1:0];
                        w_res_cnt_nxt  = w_t - c_FULL;
                        w_state_nxt    = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    w_emit         = 1'b1;
                    w_odata        = r_res_data;
                    w_okeep        = f_msb_mask(r_res_cnt);
                    w_olast        = 1'b1;
                    w_res_data_nxt = '0;
                    w_res_cnt_nxt  = '0;
                    w_state_nxt    = S_FIRST;
                end
            end
            default: w_state_nxt = S_FIRST;
        endcase
    end

    // Residual, output register (held while stalled) and header capture.
    always_ff @(posedge r_sys_clk or negedge r_sys_rstn) begin
        if (!r_sys_rstn) begin
            r_res_data     <= '0;
            r_res_cnt      <= '0;
            r_valid_out    <= 1'b0;
            r_data_out     <= '0;
            r_keep_out     <= '0;
            r_last_out     <= 1'b0;
            r_valid_header <= 1'b0;
            r_data_header  <= '0;
            r_keep_header  <= '0;
        end else begin
            r_res_data     <= w_res_data_nxt;
            r_res_cnt      <= w_res_cnt_nxt;
            r_valid_header <= w_hdr_ld;
            if (w_emit) begin
                r_valid_out <= 1'b1;
                r_data_out  <= w_odata;
                r_keep_out  <= w_okeep;
                r_last_out  <= w_olast;
            end else if (ready_out) begin
                r_valid_out <= 1'b0;
            end
            if (w_hdr_ld) begin
                r_data_header <= w_hdr_data;
                r_keep_header <= w_hdr_keep;
            end
        end
    end

    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign keep_out     = r_keep_out;
    assign last_out     = r_last_out;
    assign valid_header = r_valid_header;
    assign data_header  = r_data_header;
    assign keep_header  = r_keep_header;

`ifdef AXI_STRIP_ERR_EN
    logic r_err_keep;
    logic w_keep_bad;

    // Illegal: holes in keep, or a partial beat that is not the last one.
    assign w_keep_bad = (keep_in != f_msb_mask(w_n))
                     || ((keep_in != c_KEEP_ALL) && !last_in);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge r_sys_clk or negedge r_sys_rstn) begin
        if (!r_sys_rstn)              r_err_keep <= 1'b0;
        else if (w_acc && w_keep_bad) r_err_keep <= 1'b1;
    end

    assign err_keep = r_err_keep;
`else
    assign err_keep = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_strip_header.sv
//============================================================================
// Module      : tb_axi_strip_header
// Description : Scoreboard bench for axi_strip_header. Stimulus pushes the
//               expected payload beats and headers into queues; a monitor
//               pops and compares whenever the DUT presents them.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_axi_strip_header;

    logic        r_sys_clk      = 1'b0;
    logic        r_sys_rstn     = 1'b0;
    logic        valid_in       = 1'b0;
    logic [31:0] data_in        = '0;
    logic [3:0]  keep_in        = '0;
    logic        last_in        = 1'b0;
    logic        ready_out      = 1'b1;
    logic [2:0]  byte_strip_cnt = '0;
    logic        ready_in, valid_out, last_out, valid_header, err_keep;
    logic [31:0] data_out, data_header;
    logic [3:0]  keep_out, keep_header;

    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
    typedef struct packed { logic [31:0] d; logic [3:0] k; } hdr_t;

    beat_t exp_q[$];
    hdr_t  hdr_q[$];
    beat_t m_exp, m_prev;
    hdr_t  m_hdr;
    bit    m_stall    = 1'b0;
    bit    rand_ready = 1'b0;
    int    n_cmp      = 0;
    int    n_err      = 0;

    axi_strip_header #(.DATA_WD(32), .DATA_BYTE_WD(4), .CNT_WD(3)) dut (
        .r_sys_clk(r_sys_clk), .r_sys_rstn(r_sys_rstn),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out), .byte_strip_cnt(byte_strip_cnt),
        .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
        .err_keep(err_keep)
    );

    always #5 r_sys_clk = ~r_sys_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] km(input int n);
        km = 4'hF << (4 - n);
    endfunction

    // Downstream ready: always high in directed tests, random in stress test.
    initial forever begin
        @(posedge r_sys_clk);
        #1;
        ready_out = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: compares output beats, stall stability and header captures.
    initial forever begin
        @(negedge r_sys_clk);
        if (!r_sys_rstn) begin
            m_stall = 1'b0;
        end else begin
            if (m_stall)
                chk("stall_hold", {valid_out, last_out, keep_out, data_out},
                    {1'b1, m_prev.l, m_prev.k, m_prev.d});
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got %0h keep %0h last %0b, none expected",
                             data_out, keep_out, last_out);
                end else begin
                    m_exp = exp_q.pop_front();
                    chk("out_beat", {data_out, keep_out, last_out}, {m_exp.d, m_exp.k, m_exp.l});
                end
            end
            m_stall = valid_out && !ready_out;
            m_prev  = '{d: data_out, k: keep_out, l: last_out};
            if (valid_header) begin
                if (hdr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_header: got %0h keep %0h", data_header, keep_header);
                end else begin
                    m_hdr = hdr_q.pop_front();
                    chk("header", {data_header, keep_header}, {m_hdr.d, m_hdr.k});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge r_sys_clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [2:0] k, input logic [31:0] d, input logic [3:0] kp, input logic l);
        int t;
        t = 0;
        valid_in = 1'b1; data_in = d; keep_in = kp; last_in = l; byte_strip_cnt = k;
        forever begin
            @(negedge r_sys_clk);
            if (ready_in) break;
            t++;
            if (t > 200) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: ready_in stuck at %0b, required 1", ready_in);
                break;
            end
        end
        @(posedge r_sys_clk);
        #1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    endtask

    function automatic void exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back('{d: d, k: k, l: l});
    endfunction

    function automatic void exp_hdr(input logic [31:0] d, input logic [3:0] k);
        hdr_q.push_back('{d: d, k: k});
    endfunction

    task automatic async_reset();
        #2 r_sys_rstn = 1'b0;
        #1;
        chk("arst_ready_in", ready_in, 1);
        chk("arst_valid_out", valid_out, 0);
        chk("arst_err_keep", err_keep, 0);
        #3 r_sys_rstn = 1'b1;
        @(posedge r_sys_clk);
        #1;
    endtask

    // 8-beat packet of incrementing bytes; expectation is the byte stream
    // minus the first k bytes, chunked into 4-byte beats.
    task automatic rand_pkt(input logic [2:0] k, input logic [7:0] base, input int nl);
        int          plen, c;
        logic [31:0] d;
        beat_t       e;
        plen = 28 + nl - int'(k);
        d = '0;
        for (int i = 0; i < int'(k); i++) d[31-8*i -: 8] = base + 8'(i);
        exp_hdr(d, km(int'(k)));
        for (int j = 0; 4 * j < plen; j++) begin
            c = (plen - 4 * j > 4) ? 4 : plen - 4 * j;
            e.d = '0;
            for (int i = 0; i < c; i++) e.d[31-8*i -: 8] = base + 8'(int'(k) + 4 * j + i);
            e.k = km(c);
            e.l = (4 * (j + 1) >= plen);
            exp_q.push_back(e);
        end
        for (int b = 0; b < 8; b++) begin
            idle($urandom_range(0, 2));
            for (int i = 0; i < 4; i++) d[31-8*i -: 8] = base + 8'(4 * b + i);
            send(k, d, (b == 7) ? km(nl) : 4'hF, b == 7);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && (exp_q.size() != 0 || hdr_q.size() != 0); i++)
            @(posedge r_sys_clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_ready_in", ready_in, 1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_keep_out", keep_out, 0);
        chk("rst_last_out", last_out, 0);
        chk("rst_valid_header", valid_header, 0);
        chk("rst_data_header", data_header, 0);
        chk("rst_keep_header", keep_header, 0);
        chk("rst_err_keep", err_keep, 0);
        #10 r_sys_rstn = 1'b1;
        @(posedge r_sys_clk);
        #1;

        // k=3, three beats
        exp_hdr(32'h10203000, 4'b1110);
        exp_beat(32'h40112131, 4'b1111, 1'b0);
        exp_beat(32'h41120000, 4'b1100, 1'b1);
        send(3'd3, 32'h10203040, 4'b1111, 1'b0);
        send(3'd3, 32'h11213141, 4'b1111, 1'b0);
        send(3'd3, 32'h12223242, 4'b1000, 1'b1);

        // k=1, last beat overflows into a flush beat
        exp_hdr(32'hA0000000, 4'b1000);
        exp_beat(32'hA1A2A3B0, 4'b1111, 1'b0);
        exp_beat(32'hB1B2B300, 4'b1110, 1'b1);
        send(3'd1, 32'hA0A1A2A3, 4'b1111, 1'b0);
        send(3'd1, 32'hB0B1B2B3, 4'b1111, 1'b1);
        @(negedge r_sys_clk);
        chk("flush_ready_in", ready_in, 0);
        idle(1);

        // k=0 pass-through
        exp_hdr(32'h0, 4'b0000);
        exp_beat(32'h01020304, 4'b1111, 1'b0);
        exp_beat(32'h05060708, 4'b1111, 1'b0);
        exp_beat(32'h090A0000, 4'b1100, 1'b1);
        send(3'd0, 32'h01020304, 4'b1111, 1'b0);
        send(3'd0, 32'h05060708, 4'b1111, 1'b0);
        send(3'd0, 32'h090A0B0C, 4'b1100, 1'b1);

        // k=4: first beat dropped
        exp_hdr(32'h01020304, 4'b1111);
        exp_beat(32'h05060708, 4'b1111, 1'b0);
        exp_beat(32'h090A0000, 4'b1100, 1'b1);
        send(3'd4, 32'h01020304, 4'b1111, 1'b0);
        send(3'd4, 32'h05060708, 4'b1111, 1'b0);
        send(3'd4, 32'h090A0B0C, 4'b1100, 1'b1);

        // k=3 single short beat: header only, no payload
        exp_hdr(32'hC0C10000, 4'b1100);
        send(3'd3, 32'hC0C10000, 4'b1100, 1'b1);

        // k=7 saturates to 4: single full beat fully consumed
        exp_hdr(32'hDEADBEEF, 4'b1111);
        send(3'd7, 32'hDEADBEEF, 4'b1111, 1'b1);

        // k=2 single beat with one payload byte left
        exp_hdr(32'h11220000, 4'b1100);
        exp_beat(32'h33000000, 4'b1000, 1'b1);
        send(3'd2, 32'h11223344, 4'b1110, 1'b1);

        // k=2, last beat exactly fills one output beat (no flush)
        exp_hdr(32'hAABB0000, 4'b1100);
        exp_beat(32'hCCDDEEFF, 4'b1111, 1'b1);
        send(3'd2, 32'hAABBCCDD, 4'b1111, 1'b0);
        send(3'd2, 32'hEEFF0011, 4'b1100, 1'b1);
        drain();

        // Random valid/ready gaps over 8-beat packets
        rand_ready = 1'b1;
        rand_pkt(3'd2, 8'h20, 4);
        rand_pkt(3'd1, 8'h60, 1);
        rand_pkt(3'd3, 8'h90, 3);
        drain();
        rand_ready = 1'b0;
        idle(2);

        // Asynchronous reset mid-packet discards the partial packet
        exp_hdr(32'h99000000, 4'b1000);
        send(3'd1, 32'h99AABBCC, 4'b1111, 1'b0);
        idle(1);
        async_reset();
        exp_hdr(32'h55000000, 4'b1000);
        exp_beat(32'h66778800, 4'b1110, 1'b1);
        send(3'd1, 32'h55667788, 4'b1111, 1'b1);
        drain();

`ifdef AXI_STRIP_ERR_EN
        // Hole in keep on a non-last beat sets the sticky error
        exp_hdr(32'h0, 4'b0000);
        exp_beat(32'h11220000, 4'b1100, 1'b0);
        send(3'd0, 32'h11223344, 4'b1010, 1'b0);
        idle(2);
        chk("err_keep_set", err_keep, 1);
        idle(3);
        chk("err_keep_sticky", err_keep, 1);
        async_reset();
        exp_hdr(32'h55000000, 4'b1000);
        exp_beat(32'h66778800, 4'b1110, 1'b1);
        send(3'd1, 32'h55667788, 4'b1111, 1'b1);
        drain();
        chk("err_keep_after_rst", err_keep, 0);
`endif

        chk("exp_q_empty", exp_q.size(), 0);
        chk("hdr_q_empty", hdr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
